// File: rtl/sap1_datapath.sv
// SAP-1 datapath: PC, IR, program/data RAM, ACC, B, ALU, output register and flags.
// Executes sequencer control words and returns opcode and zero flag to close the loop.
module sap1_datapath #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        state,
    input  logic              pc_inc,
    input  logic              pc_jmp,
    input  logic              mem_read,
    input  logic              acc_load,
    input  logic              b_load,
    input  logic              out_load,
    input  logic [2:0]        alu_op,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [3:0]        opcode,
    output logic              zero_flag,
    output logic              carry_flag,
    output logic [DATA_W-1:0] out_value,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] acc,
    output logic              halted
);

    localparam logic [1:0] StFetch   = 2'b00;
    localparam logic [1:0] StExecute = 2'b10;

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] b_q, b_d;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W:0]   sum, diff;
    logic [DATA_W-1:0] alu_res, acc_d;
    logic              alu_carry;

    assign opcode   = ir_q[DATA_W-1 -: 4];
    assign rd_addr  = (state == StFetch) ? pc : ir_q[ADDR_W-1:0];
    assign mem_data = mem[rd_addr];
    assign sum      = {1'b0, acc} + {1'b0, mem_data};
    // Top bit of the widened difference is the borrow (operand > ACC).
    assign diff     = {1'b0, acc} - {1'b0, mem_data};

    // Program RAM is not reset; a write is seen by reads from the next cycle.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_comb begin
        alu_res   = mem_data;
        alu_carry = carry_flag;
        case (alu_op)
            3'b000: begin
                alu_res   = sum[DATA_W-1:0];
                alu_carry = sum[DATA_W];
            end
            3'b001: begin
                alu_res   = diff[DATA_W-1:0];
                alu_carry = diff[DATA_W];
            end
            3'b010:  alu_res = acc & mem_data;
            3'b011:  alu_res = acc | mem_data;
            3'b100:  alu_res = acc ^ mem_data;
            default: alu_res = mem_data;
        endcase
    end

    always_comb begin
        acc_d = b_load ? alu_res : mem_data;
        b_d   = b_load ? mem_data : b_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= '0;
            ir_q       <= '0;
            acc        <= '0;
            b_q        <= '0;
            out_value  <= '0;
            zero_flag  <= 1'b1;
            carry_flag <= 1'b0;
            halted     <= 1'b0;
        end else if (!halted) begin
            if (state == StFetch && mem_read) begin
                ir_q <= mem_data;
            end
            if (acc_load) begin
                acc       <= acc_d;
                zero_flag <= (acc_d == '0);
            end
            if (acc_load && b_load) begin
                carry_flag <= alu_carry;
            end
            b_q <= b_d;
            if (out_load) begin
                out_value <= acc;
            end
            if (pc_jmp) begin
                pc <= ir_q[ADDR_W-1:0];
            end else if (pc_inc) begin
                pc <= pc + ADDR_W'(1);
            end
            if (state == StExecute && opcode == 4'hF) begin
                halted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sap1_datapath.sv
// Scoreboard bench for sap1_datapath: a behavioural model predicts every cycle's
// registered outputs; a monitor pops and compares them after each clock.
module tb_sap1_datapath;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] state = 2'b11;
    logic       pc_inc = 0, pc_jmp = 0, mem_read = 0, acc_load = 0, b_load = 0, out_load = 0;
    logic [2:0] alu_op = 3'd0;
    logic       prog_we = 0;
    logic [3:0] prog_addr = 4'd0;
    logic [7:0] prog_data = 8'd0;
    logic [3:0] opcode;
    logic       zero_flag, carry_flag, halted;
    logic [7:0] out_value, acc;
    logic [3:0] pc;

    sap1_datapath dut (
        .clk(clk), .reset(reset), .state(state), .pc_inc(pc_inc), .pc_jmp(pc_jmp),
        .mem_read(mem_read), .acc_load(acc_load), .b_load(b_load), .out_load(out_load),
        .alu_op(alu_op), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .opcode(opcode), .zero_flag(zero_flag), .carry_flag(carry_flag),
        .out_value(out_value), .pc(pc), .acc(acc), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] opc;
        logic       z, c, h;
        logic [7:0] outv, accv;
        logic [3:0] pcv;
    } exp_t;

    exp_t q[$];
    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_pc, m_ir, m_acc, m_out;
    bit m_z, m_c, m_h;
    int mem [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    always begin
        @(negedge clk);
        #2;
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("opcode", 32'(opcode), 32'(e.opc));
            chk("zero_flag", 32'(zero_flag), 32'(e.z));
            chk("carry_flag", 32'(carry_flag), 32'(e.c));
            chk("out_value", 32'(out_value), 32'(e.outv));
            chk("pc", 32'(pc), 32'(e.pcv));
            chk("acc", 32'(acc), 32'(e.accv));
            chk("halted", 32'(halted), 32'(e.h));
        end
    end

    function automatic exp_t snap();
        exp_t e;
        e.opc  = 4'(m_ir >> 4);
        e.z    = m_z;
        e.c    = m_c;
        e.h    = m_h;
        e.outv = 8'(m_out);
        e.accv = 8'(m_acc);
        e.pcv  = 4'(m_pc);
        return e;
    endfunction

    task automatic model_reset();
        m_pc = 0; m_ir = 0; m_acc = 0; m_out = 0;
        m_z = 1; m_c = 0; m_h = 0;
    endtask

    task automatic model_step(input int st, input bit inc, jmp, rd, al, bl, ol,
                              input int op, input bit we, input int wa, input int wd);
        int md, old_acc, old_pc, old_ir, r;
        md = mem[(st == 0) ? m_pc : (m_ir % 16)];
        if (we) mem[wa] = wd;
        if (m_h) return;
        old_acc = m_acc; old_pc = m_pc; old_ir = m_ir;
        if (st == 0 && rd) m_ir = md;
        if (al && bl) begin
            case (op)
                0: begin r = old_acc + md; m_c = (r > 255); m_acc = r % 256; end
                1: begin m_c = (md > old_acc); m_acc = (old_acc - md + 256) % 256; end
                2: m_acc = old_acc & md;
                3: m_acc = old_acc | md;
                4: m_acc = old_acc ^ md;
                default: m_acc = md;
            endcase
            m_z = (m_acc == 0);
        end else if (al) begin
            m_acc = md;
            m_z = (md == 0);
        end
        if (ol) m_out = old_acc;
        if (jmp) m_pc = old_ir % 16;
        else if (inc) m_pc = (old_pc + 1) % 16;
        if (st == 2 && (old_ir / 16) == 15) m_h = 1;
    endtask

    task automatic step(input bit [1:0] st, input bit inc, jmp, rd, al, bl, ol,
                        input bit [2:0] op, input bit we, input bit [3:0] wa, input bit [7:0] wd);
        @(negedge clk);
        reset = 0; state = st; pc_inc = inc; pc_jmp = jmp; mem_read = rd;
        acc_load = al; b_load = bl; out_load = ol; alu_op = op;
        prog_we = we; prog_addr = wa; prog_data = wd;
        model_step(int'(st), inc, jmp, rd, al, bl, ol, int'(op), we, int'(wa), int'(wd));
        @(posedge clk);
        q.push_back(snap());
    endtask

    // Reset is raised after the monitor has sampled, with strobes active.
    task automatic do_reset();
        @(negedge clk);
        #3;
        reset = 1; state = 2'b10; acc_load = 1; pc_inc = 1; out_load = 1; prog_we = 0;
        model_reset();
        @(posedge clk);
        q.push_back(snap());
    endtask

    task automatic wr(input bit [3:0] a, input bit [7:0] d);
        step(2'b11, 0, 0, 0, 0, 0, 0, 3'd0, 1, a, d);
    endtask
    task automatic fetch();  step(2'b00, 1, 0, 1, 0, 0, 0, 3'd0, 0, 4'd0, 8'd0); endtask
    task automatic decode(); step(2'b01, 0, 0, 0, 0, 0, 0, 3'd0, 0, 4'd0, 8'd0); endtask
    task automatic lda();
        fetch(); decode(); step(2'b10, 0, 0, 0, 1, 0, 0, 3'd0, 0, 4'd0, 8'd0);
    endtask
    task automatic alu(input bit [2:0] op);
        fetch(); decode(); step(2'b10, 0, 0, 0, 1, 1, 0, op, 0, 4'd0, 8'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 0;
        model_reset();
        do_reset();
        for (int i = 0; i < 16; i++) wr(4'(i), 8'h00);

        // Program load + LDA
        wr(4'd0, 8'h0E); wr(4'd14, 8'h2A); lda();
        // ADD with carry, then SUB to zero
        wr(4'd1, 8'h0D); wr(4'd13, 8'hF0); lda();
        wr(4'd2, 8'h1F); wr(4'd15, 8'h20); alu(3'd0);
        wr(4'd3, 8'h2C); wr(4'd12, 8'h10); alu(3'd1);
        // Jump priority, then jump to 15 and wrap
        wr(4'd4, 8'h63); fetch(); decode(); step(2'b10, 1, 1, 0, 0, 0, 0, 3'd0, 0, 4'd0, 8'd0);
        wr(4'd3, 8'h6F); fetch(); decode(); step(2'b10, 0, 1, 0, 0, 0, 0, 3'd0, 0, 4'd0, 8'd0);
        step(2'b01, 1, 0, 0, 0, 0, 0, 3'd0, 0, 4'd0, 8'd0);
        // OUT with simultaneous ACC load
        wr(4'd0, 8'h0B); wr(4'd11, 8'h05); lda();
        wr(4'd1, 8'h0A); wr(4'd10, 8'h09); fetch(); decode();
        step(2'b10, 0, 0, 0, 1, 0, 1, 3'd0, 0, 4'd0, 8'd0);
        // Program write colliding with fetch of the same address
        wr(4'd2, 8'h0E); wr(4'd9, 8'h77);
        step(2'b00, 1, 0, 1, 0, 0, 0, 3'd0, 1, 4'd2, 8'h09); decode();
        step(2'b10, 0, 0, 0, 1, 0, 0, 3'd0, 0, 4'd0, 8'd0);
        // HLT, then suppressed strobes and a RAM write while halted
        wr(4'd3, 8'hF0); fetch(); decode(); step(2'b10, 0, 0, 0, 0, 0, 0, 3'd0, 0, 4'd0, 8'd0);
        step(2'b01, 1, 0, 0, 1, 0, 1, 3'd0, 0, 4'd0, 8'd0);
        step(2'b10, 1, 1, 0, 1, 1, 0, 3'd0, 0, 4'd0, 8'd0);
        wr(4'd5, 8'h33);
        // Reset mid-EXECUTE; RAM survives
        do_reset();
        wr(4'd0, 8'h0E); lda();
        do_reset();
        wr(4'd0, 8'h05); lda();

        // Randomized control words
        for (int n = 0; n < 400; n++) begin
            if (n % 60 == 59) do_reset();
            step(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) == 0),
                 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        end

        for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk);
        @(negedge clk);
        #4;
        if (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sap1_datapath.md
# sap1_datapath

- Executes the control words issued by the SAP-1 sequencer.
- Contains the program counter, instruction register, 16-entry program/data RAM, accumulator, B register, ALU, output register and flags.
- Returns the current opcode and zero flag to the sequencer, closing the control loop.
- Has a side port for loading programs into RAM.

## Interface
- DATA_W, 8, width of RAM words, ACC, B, ALU and output register
- ADDR_W, 4, address and PC width; RAM depth is 2^ADDR_W
- clk  input  1  clock, all registers update on the rising edge
- reset  input  1  asynchronous, active-high
- state  input  2  sequencer phase: 00 FETCH, 01 DECODE, 10 EXECUTE; 11 is treated as DECODE (no register updates)
- pc_inc, pc_jmp, mem_read, acc_load, b_load, out_load  input  1 each  control strobes
- alu_op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, others pass B
- prog_we  input  1  RAM write enable (program load)
- prog_addr  input  ADDR_W  RAM write address
- prog_data  input  DATA_W  RAM write data
- opcode  output  4  IR[7:4]
- zero_flag  output  1  registered, ACC == 0
- carry_flag  output  1  registered carry (ADD) / borrow (SUB)
- out_value  output  DATA_W  output register
- pc  output  ADDR_W  program counter
- acc  output  DATA_W  accumulator
- halted  output  1  sticky, set on HLT (opcode 1111) in EXECUTE

## Operation
- **RAM**
  - Asynchronous read; synchronous write when prog_we = 1.
  - Not reset.
  - Read address is pc when state = FETCH, otherwise IR[3:0].
- **Fetch:** when state = FETCH and mem_read = 1, IR <= RAM[pc]. mem_read outside FETCH never loads IR.
- **Memory operand:** mem_data = RAM[IR[3:0]].
- **LDA:** acc_load = 1 and b_load = 0 in EXECUTE gives ACC <= mem_data.
- **ALU op:** acc_load = 1 and b_load = 1 in the same cycle gives B <= mem_data and ACC <= ALU(ACC, mem_data).
  - The ALU uses the freshly read operand, not the stale B.
- **ALU arithmetic:**
  - ADD is a (DATA_W+1)-bit sum; carry_flag <= bit DATA_W.
  - SUB computes ACC - operand modulo 2^DATA_W; carry_flag <= 1 when operand > ACC (borrow).
  - Logic ops and LDA leave carry_flag unchanged.
- **zero_flag:** updated only on acc_load, to (new ACC == 0). Otherwise it holds.
- **b_load alone:** B <= mem_data, ACC unchanged.
- **out_load:** out_value <= ACC (the pre-edge value).
- **PC update:**
  - pc_jmp = 1 gives PC <= IR[3:0]. pc_jmp has priority over pc_inc.
  - pc_inc = 1 alone gives PC <= PC + 1, wrapping 15 -> 0.
- **halted:** set when state = EXECUTE and opcode = 1111. While halted = 1, all register updates except RAM writes are suppressed. Only reset clears it.
- **Strobes outside their phase:** acc_load, b_load, out_load, pc_inc and pc_jmp act in any state. The sequencer is responsible for asserting them only in EXECUTE.
- **Program-load / read collision:** prog_we writing the address currently being read means the read returns the old word that cycle; the new word is visible from the next cycle.

## Timing
- **Reset values:**
  - PC = 0, IR = 0 (opcode = 0000), ACC = 0, B = 0, out_value = 0.
  - zero_flag = 1, carry_flag = 0, halted = 0.
- **Reset mid-operation:** takes effect immediately. Pending strobes are ignored until reset deasserts. RAM contents survive.
- **Latency:** all register results are visible one clock after the strobe edge. opcode is valid in the cycle after FETCH, i.e. DECODE, and holds through EXECUTE.
- **Instruction timing:** three cycles per instruction (FETCH, DECODE, EXECUTE), with no stalls. JZ samples zero_flag as registered before the EXECUTE edge.
- **Simultaneous events:** pc_jmp + pc_inc means jump; acc_load + out_load means out_value gets the old ACC.

## Test plan
- **Program load + LDA:** write RAM[0] = 0x0E, RAM[14] = 0x2A; drive FETCH/DECODE/EXECUTE with LDA strobes -> acc = 0x2A, zero_flag = 0, pc = 1.
- **ADD carry:** ACC = 0xF0, RAM[15] = 0x20, ADD 15 -> acc = 0x10, carry_flag = 1, zero_flag = 0. Then SUB of 0x10 -> acc = 0x00, zero_flag = 1, carry_flag = 0.
- **Jump priority / wrap:**
  - IR = 0x63 with pc_jmp and pc_inc both high -> pc = 3.
  - pc = 15 with pc_inc -> pc = 0.
- **OUT and collision:**
  - acc_load and out_load in the same cycle, ACC 0x05 -> 0x09 -> out_value = 0x05.
  - prog_we to the address being read -> the old value is loaded.
- **HLT:** IR = 0xF0 in EXECUTE -> halted = 1. Subsequent pc_inc / acc_load pulses leave pc and acc unchanged; prog_we still writes RAM.
- **Reset mid-EXECUTE:** assert reset with acc_load high -> acc = 0, pc = 0, zero_flag = 1, halted = 0 immediately. RAM[14] still reads 0x2A.
